bht_update_ctrl: RTL and testbench

- Sequences all writes into the direct-mapped 2-bit-counter branch history table.
- After reset or on a flush request, it walks every entry and writes the weakly-not-taken value.
- In normal operation it accepts resolved-branch updates from the back end into a small FIFO, computes the saturated next counter value, and drains one write per cycle onto the single BHT write port.
- It also forwards the in-flight write value to the fetch-stage read when the indices collide.

---
 rtl/bht_update_ctrl.sv | 125 ++++++++++++
 tb/tb_bht_update_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// BHT write sequencer: clears the table after reset/flush, then drains queued
// branch-resolution updates one per cycle and forwards the in-flight write to the fetch read.
module bht_update_ctrl #(
    parameter int         SIZE     = 256,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_req,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [31:0]               upd_pc,
    input  logic                      upd_taken,
    input  logic [1:0]                upd_ctr,
    input  logic [31:0]               rd_pc,
    input  logic [1:0]                rd_ctr_raw,
    output logic [1:0]                rd_ctr,
    output logic                      rd_pred,
    output logic                      bht_we,
    output logic [$clog2(SIZE)-1:0]   bht_widx,
    output logic [1:0]                bht_wdata,
    output logic                      init_done,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int IW = $clog2(SIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {CLEAR, RUN} state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          taken;
        logic [1:0]    ctr;
    } upd_t;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    upd_t          mem_q [DEPTH];
    upd_t          head, entry_in;
    logic          push, pop;

    assign head     = mem_q[rd_ptr_q];
    assign entry_in = '{idx: upd_pc[IW+1:2], taken: upd_taken, ctr: upd_ctr};

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        bht_we    = 1'b0;
        bht_widx  = head.idx;
        bht_wdata = sat(head.ctr, head.taken);
        upd_ready = 1'b0;
        init_done = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            CLEAR: begin
                bht_we    = 1'b1;
                bht_widx  = clr_idx_q;
                bht_wdata = INIT_VAL;
                if (clr_idx_q == IW'(SIZE - 1)) state_d = RUN;
                else                            clr_idx_d = clr_idx_q + 1'b1;
            end
            RUN: begin
                init_done = 1'b1;
                upd_ready = (count_q < CW'(DEPTH));
                push      = upd_valid && upd_ready;
                pop       = (count_q != '0);
            end
            default: state_d = CLEAR;
        endcase
        // A flush kills the head write too, so nothing queued ever reaches the array.
        if (flush_req) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
            push      = 1'b0;
            pop       = 1'b0;
        end
        if (state_q == RUN) bht_we = pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            if (flush_req || state_q == CLEAR) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(push);
                rd_ptr_q <= rd_ptr_q + PW'(pop);
                count_q  <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    assign fifo_count = count_q;

    // Only the write being driven this cycle is forwarded; queued entries are not.
    assign rd_ctr  = (bht_we && bht_widx == rd_pc[IW+1:2]) ? bht_wdata : rd_ctr_raw;
    assign rd_pred = rd_ctr[1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[31:IW+2], upd_pc[1:0], rd_pc[31:IW+2], rd_pc[1:0]};

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed + randomized bench for bht_update_ctrl against a queue-based reference model.
module tb_bht_update_ctrl;
    localparam int         SIZE  = 256;
    localparam int         DEPTH = 4;
    localparam logic [1:0] INIT  = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic        upd_ready, rd_pred, bht_we, init_done;
    logic [31:0] upd_pc = '0, rd_pc = '0;
    logic [1:0]  upd_ctr = '0, rd_ctr_raw = '0, rd_ctr, bht_wdata;
    logic [7:0]  bht_widx;
    logic [2:0]  fifo_count;

    bht_update_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_ctr(upd_ctr),
        .rd_pc(rd_pc), .rd_ctr_raw(rd_ctr_raw), .rd_ctr(rd_ctr), .rd_pred(rd_pred),
        .bht_we(bht_we), .bht_widx(bht_widx), .bht_wdata(bht_wdata),
        .init_done(init_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: "clearing" walk position plus a plain queue of pending updates.
    typedef struct { int idx; int tk; int c; } ent_t;
    ent_t q[$];
    bit   clearing;
    int   clr_pos;
    int   checks = 0, failures = 0;

    function automatic int satf(input int c, input int tk);
        int n;
        n = tk ? c + 1 : c - 1;
        if (n > 3) n = 3;
        if (n < 0) n = 0;
        return n;
    endfunction

    function automatic int peek_idx();
        if (clearing) return clr_pos;
        if (q.size() > 0) return q[0].idx;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clearing = 1'b1;
        clr_pos  = 0;
        q.delete();
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model for the next posedge.
    task automatic cyc(input bit v, input logic [31:0] pc, input bit tk, input logic [1:0] c,
                       input logic [31:0] rpc, input logic [1:0] raw, input bit fl);
        bit   e_we, e_rdy, e_init, acc;
        int   e_idx, e_dat, e_rd;
        ent_t ne;
        @(negedge clk);
        upd_valid = v; upd_pc = pc; upd_taken = tk; upd_ctr = c;
        rd_pc = rpc; rd_ctr_raw = raw; flush_req = fl;
        #1;
        e_idx = 0; e_dat = 0;
        if (clearing) begin
            e_we = 1; e_idx = clr_pos; e_dat = INIT; e_rdy = 0; e_init = 0;
        end else begin
            e_init = 1;
            e_rdy  = (q.size() < DEPTH);
            e_we   = (q.size() > 0) && !fl;
            if (q.size() > 0) begin e_idx = q[0].idx; e_dat = satf(q[0].c, q[0].tk); end
        end
        e_rd = (e_we && e_idx == int'(rpc[9:2])) ? e_dat : int'(raw);
        chk("bht_we", 32'(bht_we), 32'(e_we));
        if (e_we) begin
            chk("bht_widx", 32'(bht_widx), 32'(e_idx));
            chk("bht_wdata", 32'(bht_wdata), 32'(e_dat));
        end
        chk("upd_ready", 32'(upd_ready), 32'(e_rdy));
        chk("init_done", 32'(init_done), 32'(e_init));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("rd_ctr", 32'(rd_ctr), 32'(e_rd));
        chk("rd_pred", 32'(rd_pred), 32'(e_rd >> 1));
        acc = v && e_rdy && !fl;
        if (fl) begin
            model_reset();
        end else if (clearing) begin
            if (clr_pos == SIZE - 1) clearing = 0;
            else clr_pos++;
        end else begin
            if (e_we) void'(q.pop_front());
            if (acc) begin
                ne.idx = int'(pc[9:2]); ne.tk = tk; ne.c = int'(c);
                q.push_back(ne);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; upd_valid = 0; flush_req = 0;
        #1;
        model_reset();
        chk("rst_we", 32'(bht_we), 1);
        chk("rst_widx", 32'(bht_widx), 0);
        chk("rst_wdata", 32'(bht_wdata), 32'(INIT));
        chk("rst_ready", 32'(upd_ready), 0);
        chk("rst_init", 32'(init_done), 0);
        chk("rst_count", 32'(fifo_count), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_widx", 32'(bht_widx), 0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] sc [4];
        logic [1:0] se [4];
        bit         st [4];
        logic [31:0] rpc;
        model_reset();

        // Reset release and full clear walk
        do_reset();
        idle(SIZE);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("init_rise", 32'(init_done), 1);
        chk("ready_rise", 32'(upd_ready), 1);

        // Single update, one-cycle latency
        cyc(1, 32'h0000_0010, 1, 2'b10, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        chk("lat_we", 32'(bht_we), 1);
        chk("lat_widx", 32'(bht_widx), 4);
        chk("lat_wdata", 32'(bht_wdata), 3);
        cyc(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        chk("lat_we_off", 32'(bht_we), 0);

        // Saturation corners
        sc = '{2'b11, 2'b00, 2'b01, 2'b10};
        st = '{1, 0, 0, 0};
        se = '{2'b11, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'(i * 4 + 32), st[i], sc[i], 0, 0, 0);
            cyc(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
            chk("sat_wdata", 32'(bht_wdata), 32'(se[i]));
        end

        // Forwarding hit and miss
        cyc(1, 32'h0000_001C, 1, 2'b10, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0000_001C, 2'b00, 0);
        chk("fwd_hit_ctr", 32'(rd_ctr), 3);
        chk("fwd_hit_pred", 32'(rd_pred), 1);
        cyc(1, 32'h0000_001C, 1, 2'b10, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0000_0020, 2'b00, 0);
        chk("fwd_miss_ctr", 32'(rd_ctr), 0);
        idle(1);

        // Back-to-back pushes while draining
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h100 + 32'(i * 4), 1'($urandom_range(1)), 2'($urandom_range(3)), 0, 0, 0);
            chk("cnt_le_depth", 32'(fifo_count <= 3'(DEPTH)), 1);
        end
        idle(3);

        // Flush with a queued entry and a push in the flush cycle
        cyc(1, 32'h0000_0040, 1, 2'b01, 0, 0, 0);
        cyc(1, 32'h0000_0044, 1, 2'b01, 0, 0, 1);
        chk("flush_no_write", 32'(bht_we), 0);
        idle(SIZE);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("flush_init", 32'(init_done), 1);
        chk("flush_empty", 32'(fifo_count), 0);

        // Reset mid-clear restarts the walk
        cyc(0, 0, 0, 0, 0, 0, 1);
        while (clr_pos != 100) idle(1);
        do_reset();
        idle(SIZE + 2);

        // Randomized traffic with occasional flushes and targeted forwarding reads
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom;
            if ($urandom_range(1) == 1) rpc[9:2] = 8'(peek_idx());
            cyc(1'($urandom_range(3) != 0), $urandom, 1'($urandom_range(1)), 2'($urandom_range(3)),
                rpc, 2'($urandom_range(3)), ($urandom_range(149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
